// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) transmit path.
package hamming_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;

    // Codeword index = syndrome position - 1; parity bits sit at positions 1, 2, 4.
    localparam int unsigned P0_POS = 0;
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P2_POS = 3;

    // Data bits occupy the remaining positions 3, 5, 6, 7.
    localparam int unsigned D0_POS = 2;
    localparam int unsigned D1_POS = 4;
    localparam int unsigned D2_POS = 5;
    localparam int unsigned D3_POS = 6;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } tx_state_e;

endpackage

// File: rtl/hamming_enc74.sv
// Combinational Hamming(7,4) encoder with an optional single-bit flip mask.
module hamming_enc74
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
    output logic [CW_W-1:0]   cw
);

    logic [CW_W-1:0] clean;
    logic [CW_W-1:0] mask;

    // Place data bits and compute the three even-parity bits.
    always_comb begin
        clean         = '0;
        clean[D0_POS] = data[0];
        clean[D1_POS] = data[1];
        clean[D2_POS] = data[2];
        clean[D3_POS] = data[3];
        clean[P0_POS] = data[0] ^ data[1] ^ data[3];
        clean[P1_POS] = data[0] ^ data[2] ^ data[3];
        clean[P2_POS] = data[1] ^ data[2] ^ data[3];
    end

    // Position 0 means no injection; positions 1..7 map to indices 0..6.
    always_comb begin
        mask = '0;
        if (inj_en && (inj_pos != 3'd0)) begin
            mask[inj_pos - 3'd1] = 1'b1;
        end
    end

    assign cw = clean ^ mask;

endmodule

// File: rtl/hamming_enc_tx.sv
// Streaming Hamming(7,4) encoder: 1-deep pending register feeding a framed
// serial shifter with optional inter-frame gap.
module hamming_enc_tx
    import hamming_pkg::*;
#(
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
    output logic [CW_W-1:0]   cw_out,
    output logic              cw_load,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [CW_W-1:0]  pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [CW_W-1:0]  cw_q, cw_d;
    logic             cw_load_q, cw_load_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CW_W-1:0]  enc_cw;
    logic             accept;
    logic             load;

    hamming_enc74 u_enc (
        .data    (in_data),
        .inj_en  (inj_en),
        .inj_pos (inj_pos),
        .cw      (enc_cw)
    );

    // in_ready comes straight from a register, so out_ready never reaches it.
    assign accept = in_valid && !pend_full_q;

    // Next-state: frame sequencing, pending hand-off and word acceptance.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cw_d        = cw_q;
        cw_load_d   = 1'b0;
        bit_idx_d   = bit_idx_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pend_full_q) begin
                    load = 1'b1;
                end
            end
            StShift: begin
                if (out_ready) begin
                    if (bit_idx_q == 3'd6) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        bit_idx_d   = 3'd0;
                        if (GAP_CYCLES > 0) begin
                            state_d   = StGap;
                            gap_cnt_d = 4'd0;
                        end else if (pend_full_q) begin
                            // Back-to-back frame: reload on the last-bit edge.
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StGap: begin
                // Final gap cycle acts as IDLE so the gap is exactly GAP_CYCLES long.
                if (gap_cnt_q == GAP_LAST) begin
                    if (pend_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            cw_d        = pend_q;
            cw_load_d   = 1'b1;
            pend_full_d = 1'b0;
            bit_idx_d   = 3'd0;
            state_d     = StShift;
        end

        // Cannot coincide with load: load needs pend_full, accept needs it clear.
        if (accept) begin
            pend_d      = enc_cw;
            pend_full_d = 1'b1;
        end
    end

    // State registers with synchronous reset; a partial frame is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cw_q        <= '0;
            cw_load_q   <= 1'b0;
            bit_idx_q   <= 3'd0;
            gap_cnt_q   <= 4'd0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cw_q        <= cw_d;
            cw_load_q   <= cw_load_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Serial outputs decode from registers only, so they hold while stalled.
    always_comb begin
        out_valid = (state_q == StShift);
        out_bit   = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_bit   = LSB_FIRST ? cw_q[bit_idx_q] : cw_q[3'd6 - bit_idx_q];
            out_first = (bit_idx_q == 3'd0);
            out_last  = (bit_idx_q == 3'd6);
        end
    end

    assign in_ready  = !pend_full_q;
    assign cw_out    = cw_q;
    assign cw_load   = cw_load_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Self-checking bench: DUT A (LSB first, no gap) and DUT B (MSB first, 2-cycle gap).
module tb_hamming_enc_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        inj_en;
    logic [2:0]  inj_pos;
    logic        out_ready;
    bit          sel;

    logic        in_ready_a, cw_load_a, out_bit_a, out_valid_a, out_first_a, out_last_a;
    logic        in_ready_b, cw_load_b, out_bit_b, out_valid_b, out_first_b, out_last_b;
    logic [6:0]  cw_out_a, cw_out_b;
    logic [15:0] frame_cnt_a, frame_cnt_b;

    logic        in_ready, cw_load, out_bit, out_valid, out_first, out_last;
    logic [6:0]  cw_out;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int frames [2];
    logic [6:0] exp_q [$];

    hamming_enc_tx u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && !sel),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .cw_out    (cw_out_a),
        .cw_load   (cw_load_a),
        .out_bit   (out_bit_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_first (out_first_a),
        .out_last  (out_last_a),
        .frame_cnt (frame_cnt_a)
    );

    hamming_enc_tx #(
        .LSB_FIRST  (1'b0),
        .GAP_CYCLES (2),
        .CNT_W      (16)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && sel),
        .in_ready  (in_ready_b),
        .in_data   (in_data),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .cw_out    (cw_out_b),
        .cw_load   (cw_load_b),
        .out_bit   (out_bit_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_first (out_first_b),
        .out_last  (out_last_b),
        .frame_cnt (frame_cnt_b)
    );

    assign in_ready  = sel ? in_ready_b  : in_ready_a;
    assign cw_load   = sel ? cw_load_b   : cw_load_a;
    assign cw_out    = sel ? cw_out_b    : cw_out_a;
    assign out_bit   = sel ? out_bit_b   : out_bit_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign out_first = sel ? out_first_b : out_first_a;
    assign out_last  = sel ? out_last_b  : out_last_a;
    assign frame_cnt = sel ? frame_cnt_b : frame_cnt_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] data;
        logic       ie;
        logic [2:0] ip;
        logic [6:0] exp_cw;
    } vec_t;

    // Reference encoder built from Hamming theory: data at non-power-of-two
    // positions, parity p covers every position whose number has bit p set.
    function automatic logic [6:0] model_cw(input logic [3:0] d, input logic ie,
                                            input logic [2:0] ip);
        logic [6:0] cw;
        int k;
        logic par;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos-1];
            end
            cw[p-1] = par;
        end
        if (ie && (ip != 3'd0)) cw[ip-1] = ~cw[ip-1];
        return cw;
    endfunction

    function automatic int syndrome(input logic [6:0] cw);
        int s;
        s = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if (cw[pos-1]) s = s ^ pos;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] d, input logic ie, input logic [2:0] ip);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        inj_en   = ie;
        inj_pos  = ip;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        inj_en   = 1'b0;
        inj_pos  = 3'd0;
        chk("in_ready low with pending", in_ready, 0);
    endtask

    // Waits for a load, checks cw_out, then takes 7 handshakes with the given
    // repeating out_ready pattern, checking order, markers and stall stability.
    task automatic collect_frame(input logic [6:0] exp_in, input bit use_q,
                                 input logic [3:0] pat, output int waited, output int gaps);
        int got;
        int n;
        logic [6:0] exp_cw;
        logic [2:0] idx;
        logic       hold_v;
        logic [2:0] hold;
        waited = 0;
        gaps   = 0;
        while (!cw_load && waited < 200) begin
            tick();
            waited++;
        end
        chk("cw_load pulse", cw_load, 1);
        exp_cw = exp_in;
        if (use_q) begin
            chk("scoreboard nonempty", exp_q.size() > 0, 1);
            exp_cw = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h0;
        end
        chk("cw_out", cw_out, exp_cw);
        got    = 0;
        n      = 0;
        hold_v = 1'b0;
        hold   = 3'b0;
        while (got < 7 && n < 200) begin
            out_ready = pat[n % 4];
            if (hold_v) chk("stall hold", {out_bit, out_first, out_last}, hold);
            if (!out_valid) gaps++;
            hold_v = out_valid && !out_ready;
            hold   = {out_bit, out_first, out_last};
            if (out_valid && out_ready) begin
                idx = sel ? 3'(6 - got) : 3'(got);
                chk("out_bit", out_bit, exp_cw[idx]);
                chk("out_first", out_first, got == 0);
                chk("out_last", out_last, got == 6);
                got++;
            end
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("handshakes", got, 7);
        frames[sel] = frames[sel] + 1;
        chk("frame_cnt", frame_cnt, frames[sel] & 32'hFFFF);
    endtask

    vec_t vecs [7];
    int   w, g, w2, g2;

    initial begin
        vecs[0] = '{4'b1011, 1'b0, 3'd0, 7'b1010101};
        vecs[1] = '{4'b0001, 1'b0, 3'd0, 7'b0000111};
        vecs[2] = '{4'b1111, 1'b0, 3'd0, 7'b1111111};
        vecs[3] = '{4'b1011, 1'b1, 3'd3, 7'b1010001};
        vecs[4] = '{4'b0110, 1'b1, 3'd7, 7'b1110011};
        vecs[5] = '{4'b0110, 1'b1, 3'd0, 7'b0110011};
        vecs[6] = '{4'b0000, 1'b0, 3'd5, 7'b0000000};

        sel       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        inj_en    = 1'b0;
        inj_pos   = 3'd0;
        out_ready = 1'b1;
        frames[0] = 0;
        frames[1] = 0;
        tick();
        tick();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset cw_out", cw_out, 0);
        chk("reset cw_load", cw_load, 0);
        chk("reset frame_cnt", frame_cnt, 0);
        chk("reset markers", {out_bit, out_first, out_last}, 0);
        rst = 1'b0;

        // Single frames from idle, with and without injection.
        for (int i = 0; i < 7; i++) begin
            fork
                send_word(vecs[i].data, vecs[i].ie, vecs[i].ip);
                collect_frame(vecs[i].exp_cw, 1'b0, 4'b1111, w, g);
            join
            chk("first-bit latency", w, 2);
            chk("no bubbles", g, 0);
            chk("syndrome", syndrome(cw_out), (vecs[i].ie && vecs[i].ip != 0) ? vecs[i].ip : 0);
        end

        // Back-to-back frames: reload on the last-bit edge, 14 valid cycles.
        fork
            begin
                send_word(4'b0001, 1'b0, 3'd0);
                send_word(4'b1111, 1'b0, 3'd0);
            end
            begin
                collect_frame(7'b0000111, 1'b0, 4'b1111, w, g);
                collect_frame(7'b1111111, 1'b0, 4'b1111, w2, g2);
            end
        join
        chk("b2b frame1 bubbles", g, 0);
        chk("b2b reload wait", w2, 0);
        chk("b2b frame2 bubbles", g2, 0);
        chk("b2b idle after", out_valid, 0);

        // Stalls with a second word waiting in the pending register.
        fork
            begin
                send_word(4'b0000, 1'b0, 3'd0);
                send_word(4'b1011, 1'b0, 3'd0);
            end
            begin
                collect_frame(7'b0000000, 1'b0, 4'b1001, w, g);
                collect_frame(7'b1010101, 1'b0, 4'b1111, w2, g2);
            end
        join
        chk("stall reload wait", w2, 0);

        // Reset mid-frame at bit_idx 3, with a word offered during reset.
        send_word(4'b0110, 1'b0, 3'd0);
        tick();
        chk("mid-frame load", cw_load, 1);
        tick();
        tick();
        tick();
        chk("mid-frame valid", out_valid, 1);
        chk("mid-frame first clear", out_first, 0);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        rst      = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        frames[0] = 0;
        frames[1] = 0;
        chk("rst out_valid", out_valid, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst cw_out", cw_out, 0);
        tick();
        chk("rst no stale load", cw_load, 0);
        chk("rst still idle", out_valid, 0);
        fork
            send_word(4'b1011, 1'b0, 3'd0);
            collect_frame(7'b1010101, 1'b0, 4'b1111, w, g);
        join
        chk("post-reset latency", w, 2);

        // DUT B: MSB first with a 2-cycle gap between queued frames.
        sel = 1'b1;
        fork
            begin
                send_word(4'b1011, 1'b0, 3'd0);
                send_word(4'b1011, 1'b0, 3'd0);
                send_word(4'b0001, 1'b0, 3'd0);
            end
            begin
                collect_frame(7'b1010101, 1'b0, 4'b1111, w, g);
                chk("gap first latency", w, 2);
                collect_frame(7'b1010101, 1'b0, 4'b1111, w, g);
                chk("gap cycles", w, 2);
                collect_frame(7'b0000111, 1'b0, 4'b1111, w, g);
                chk("gap cycles 2", w, 2);
            end
        join
        tick();
        chk("gap idle after", out_valid, 0);
        sel = 1'b0;

        // Random traffic on DUT A against the reference model.
        fork
            begin
                logic [3:0] d;
                logic       ie;
                logic [2:0] ip;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    d  = 4'($urandom);
                    ie = ($urandom_range(0, 2) == 0);
                    ip = 3'($urandom);
                    exp_q.push_back(model_cw(d, ie, ip));
                    send_word(d, ie, ip);
                end
            end
            begin
                int rw, rg;
                for (int k = 0; k < 40; k++) begin
                    collect_frame(7'h0, 1'b1, 4'($urandom) | 4'b0001, rw, rg);
                end
            end
        join
        chk("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hamming_enc_tx.md
Name: hamming_enc_tx

Overview:
Streaming Hamming(7,4) encoder and serial transmitter, the transmit-side partner of the team's Hamming(7,4) detector/corrector.
- Accepts 4-bit data words over a valid/ready handshake and computes the 7-bit codeword, using the same bit layout the detector checks.
- Presents the codeword in parallel, then shifts it out one bit per handshake with frame markers.
- An optional single-bit error-injection path drives detector testing.

Parameters:
LSB_FIRST, 1, 1 = serialize cw[0] first; 0 = cw[6] first
GAP_CYCLES, 0, idle cycles forced between frames (0..15)
CNT_W, 16, width of the frame counter

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  input word valid
in_ready  output  1  pending register empty, word may be accepted
in_data  input  4  data nibble d[3:0]
inj_en  input  1  inject error into this word (sampled at accept)
inj_pos  input  3  syndrome-numbered position 1..7 to flip; 0 = none
cw_out  output  7  last codeword loaded into the shifter (after injection)
cw_load  output  1  one-cycle pulse when cw_out updates
out_bit  output  1  serial data bit
out_valid  output  1  out_bit valid
out_ready  input  1  downstream accepts out_bit
out_first  output  1  out_bit is first bit of frame
out_last  output  1  out_bit is last bit of frame
frame_cnt  output  CNT_W  frames fully transmitted, wraps

Behaviour:
- Codeword layout, index = syndrome-1:
  - cw[2]=d0, cw[4]=d1, cw[5]=d2, cw[6]=d3.
  - cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[3]=d1^d2^d3.
  - The detector yields syndrome 0 on an unmodified cw.
- Injection: if inj_en && inj_pos!=0 at accept, flip cw[inj_pos-1]. inj_pos=0 or inj_en=0 leaves the word unmodified.
- Accept: occurs when in_valid && in_ready. The encoded (and injected) word is registered into the 1-deep pending register; pend_full sets. in_ready = !pend_full (registered, no combinational path from out_ready).
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if pend_full, load the shifter from pending, clear pend_full, pulse cw_load, update cw_out, go to SHIFT with bit_idx=0.
  - SHIFT: out_valid=1. out_bit = cw[bit_idx] (LSB_FIRST) or cw[6-bit_idx]. out_first=(bit_idx==0), out_last=(bit_idx==6).
    - On out_valid&&out_ready, bit_idx increments.
    - On the handshake of the last bit, frame_cnt increments (wraps at 2^CNT_W).
    - After the last bit: if GAP_CYCLES>0, go to GAP. Otherwise, if pend_full, reload on the same edge (back-to-back frames, out_valid stays high). Otherwise go to IDLE.
  - GAP: out_valid=0. Count GAP_CYCLES cycles, then behave as IDLE.
- Stability: while out_valid && !out_ready, out_bit/out_first/out_last are held stable.
- Latency: a word accepted at edge N lands in pending at N; from IDLE, the first bit is valid after edge N+1.
- Throughput: with GAP_CYCLES=0 and out_ready=1, one frame per 7 cycles sustained. The next word is accepted while the current frame shifts.
- Simultaneous accept and pending→shifter transfer in one cycle is not possible (in_ready is low while pend_full). This costs no throughput because the pending fill occurs during the 7-cycle shift.
- Reset (any time, including mid-frame): state=IDLE, pend_full=0, bit_idx=0, cw_out=0, cw_load=0, out_valid=0, out_bit=0, out_first=0, out_last=0, frame_cnt=0, in_ready=1 after the reset edge. A partial frame is discarded and not counted.
- Inputs are ignored while rst is high.

Decomposition:
- Shared package hamming_pkg: constants CW_W=7, DATA_W=4, parity position indices (0,1,3), data position indices (2,4,5,6), FSM state enum.
- One natural sub-module: hamming_enc74, combinational 4→7 encoder plus injection XOR mask, reusable by other benches.

Test Plan:
- Reset then in_data=4'b1011, inj_en=0, out_ready=1 → cw_out=7'b1010101 with cw_load pulse; serial bits 1,0,1,0,1,0,1 with out_first on bit 0 and out_last on bit 6; frame_cnt=1.
- in_data=4'b0001, then 4'b1111 back-to-back, GAP_CYCLES=0 → cw_out 7'b0000111 then 7'b1111111; out_valid continuous for 14 cycles; frame_cnt=2.
- in_data=4'b1011, inj_en=1, inj_pos=3 → cw_out=7'b1010001; feeding it to the detector gives syndrome 3'b011 and corrected 7'b1010101.
- out_ready toggling 1,0,0,1,… during a frame of 4'b0000 → out_bit/out_last held while stalled; exactly 7 handshakes; in_ready low while pending full with a second word waiting.
- rst asserted at bit_idx=3 → next cycle out_valid=0, frame_cnt=0, in_ready=1; the next word transmits a full 7-bit frame.
- GAP_CYCLES=2, LSB_FIRST=0, two words 4'b1011 → bits 1,0,1,0,1,0,1 (MSB first), exactly 2 cycles with out_valid=0 between frames.
